// File: rtl/meter_pkg.sv
// Shared definitions for the parking meter display stage.
// Holds the display clamp value, the flash threshold, the blank segment
// pattern, the digit-to-segment table and the BCD converter state encoding.
// No ports; imported by bin2bcd_seq and meter_display.
package meter_pkg;

    localparam logic [13:0] MAX_COUNT    = 14'd9999;
    localparam logic [15:0] BLINK_THRESH = 16'd200;
    localparam logic [6:0]  SEG_BLANK    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } conv_state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    // Anything outside 0..9 shows as dark rather than a garbage glyph.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// A 14-bit value (0..9999) is zero-extended to 16 bits and shifted through a
// 32-bit register for 16 cycles, producing four BCD digits.
// Ports:
//   clk    in   1   system clock
//   reset  in   1   synchronous, active-high reset; aborts any conversion
//   start  in   1   begin a conversion when idle
//   bin    in   14  binary value to convert, already clamped to 9999
//   busy   out  1   high while a conversion is in progress (CONVERT or DONE)
//   done   out  1   high for the single cycle the result on bcd is valid
//   bcd    out  16  BCD result, digit 3 in [15:12], units in [3:0]
module bin2bcd_seq
    import meter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t state;
    conv_state_t next_state;
    logic [3:0]  iter;
    logic [31:0] shift_reg;
    logic [31:0] adjusted;
    logic [31:0] shifted;

    // State register for the converter FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one load cycle, sixteen shift cycles, one result cycle.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = CONVERT;
                end
            end
            CONVERT: begin
                if (iter == 4'd15) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One double-dabble step: correct every BCD nibble that would overflow
    // past 9 after doubling, then shift the whole register left by one.
    always_comb begin
        adjusted = shift_reg;
        for (int i = 0; i < 4; i++) begin
            if (shift_reg[16 + 4*i +: 4] >= 4'd5) begin
                adjusted[16 + 4*i +: 4] = shift_reg[16 + 4*i +: 4] + 4'd3;
            end
        end
        shifted = {adjusted[30:0], 1'b0};
    end

    // Datapath: load the operand when starting, step it while converting.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= {18'd0, bin};
                        iter      <= '0;
                    end
                end
                CONVERT: begin
                    shift_reg <= shifted;
                    iter      <= iter + 1'b1;
                end
                default: begin
                    shift_reg <= shift_reg;
                end
            endcase
        end
    end

    assign bcd = shift_reg[31:16];

endmodule

// File: rtl/meter_display.sv
// Display stage of the parking meter.
// Clamps the remaining-time count to 9999, converts it to BCD with a
// sequential converter, scans four active-low multiplexed seven-segment
// digits and applies the meter flash rules (odd-second flash below 200,
// slow flash at zero).
// Configuration macro: METER_LEADING_ZERO_BLANK_EN -- when defined, leading
// zero digits above the units digit are left dark.
// Ports:
//   clk    in   1   system clock, 100 MHz
//   reset  in   1   synchronous, active-high reset
//   count  in   16  remaining seconds, unsigned binary
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point, active-low, held off
//   an     out  4   digit enables, active-low, an[0] = units digit
module meter_display
    import meter_pkg::*;
#(
    parameter int REFRESH_COUNT = 100000,
    parameter int BLINK_HALF    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] count,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_COUNT - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_HALF - 1);

    logic [13:0]   clamped;
    logic [13:0]   sample_reg;
    logic [13:0]   disp_count;
    logic [15:0]   bcd_reg;
    logic          conv_busy;
    logic          conv_done;
    logic [15:0]   conv_bcd;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    next_seg;
    logic [3:0]    next_an;

    assign clamped = (count > 16'd9999) ? MAX_COUNT : count[13:0];

    // The converter restarts itself as soon as it returns to idle, so the
    // display tracks count with a fixed conversion period.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (1'b1),
        .bin   (clamped),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // sample_reg is captured on the same edge the converter loads its operand,
    // so disp_count always describes exactly the digits held in bcd_reg.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg <= '0;
            disp_count <= '0;
            bcd_reg    <= '0;
        end else begin
            if (!conv_busy) begin
                sample_reg <= clamped;
            end
            if (conv_done) begin
                bcd_reg    <= conv_bcd;
                disp_count <= sample_reg;
            end
        end
    end

    // Digit scan: each digit stays lit for REFRESH_COUNT cycles in turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Zero-count flash timer. Held at the start of an "on" half-period while
    // there is time left, so an expired meter always begins flashing lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (disp_count != 14'd0) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Decide what the current scan slot shows. Blanking only masks the
    // outputs; the scan and flash counters keep running underneath.
    always_comb begin
        nibble = bcd_reg[{digit_idx, 2'b00} +: 4];
        blank  = 1'b0;
        if (disp_count == 14'd0) begin
            blank = ~blink_on;
        end else if ({2'b00, disp_count} < BLINK_THRESH) begin
            blank = disp_count[0];
        end
`ifdef METER_LEADING_ZERO_BLANK_EN
        case (digit_idx)
            2'd1:    if (bcd_reg[15:4]  == 12'd0) blank = 1'b1;
            2'd2:    if (bcd_reg[15:8]  == 8'd0)  blank = 1'b1;
            2'd3:    if (bcd_reg[15:12] == 4'd0)  blank = 1'b1;
            default: blank = blank;
        endcase
`else
        blank = blank;
`endif
        if (blank) begin
            next_an  = 4'hF;
            next_seg = SEG_BLANK;
        end else begin
            next_an  = ~(4'b0001 << digit_idx);
            next_seg = seg_encode(nibble);
        end
    end

    // Anode and segment registers switch on the same edge to avoid ghosting.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= next_seg;
            an  <= next_an;
        end
    end

    assign dp = 1'b1;

endmodule
